// File: rtl/calc_btn_encoder_if.sv
//------------------------------------------------------------------------------
// Module      : calc_btn_encoder_if
// Description : Opcode request handshake between a requester and the
//               calculator button encoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface calc_btn_encoder_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;

    modport master (
        output req_valid,
        output req_op,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        output req_ready
    );
endinterface

`default_nettype wire

// File: rtl/calc_btn_encoder.sv
//------------------------------------------------------------------------------
// Module      : calc_btn_encoder
// Description : Replays an accepted ALU opcode as a timed press of the three
//               calculator buttons {btnl, btnc, btnr}, followed by a release gap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_btn_encoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    calc_btn_encoder_if.slave      req,
    output logic                   btnl,
    output logic                   btnc,
    output logic                   btnr,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             sent_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_btn;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_ready;
    logic [7:0]       r_sent;

    logic             w_legal;
    logic [2:0]       w_pat;
    logic             w_accept;

    // Button pattern per opcode; the decoder on the receive side inverts this table.
    always_comb begin
        w_legal = 1'b1;
        w_pat   = 3'b000;
        case (req.req_op)
            4'd0:    w_pat = 3'b010;
            4'd1:    w_pat = 3'b011;
            4'd2:    w_pat = 3'b000;
            4'd6:    w_pat = 3'b001;
            4'd7:    w_pat = 3'b101;
            4'd9:    w_pat = 3'b110;
            4'd10:   w_pat = 3'b111;
            4'd13:   w_pat = 3'b100;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = req.req_valid & r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_btn   <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_sent  <= 8'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_state <= S_PRESS;
                            r_btn   <= w_pat;
                            r_cnt   <= c_hold_load;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            // Rejected opcode: stay ready so a retry can land in the err cycle.
                            r_err <= 1'b1;
                        end
                    end
                end
                S_PRESS: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RELEASE;
                        r_btn   <= 3'b000;
                        r_cnt   <= c_gap_load;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_sent  <= r_sent + 8'd1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_btn   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req.req_ready = r_ready;
    assign btnl          = r_btn[2];
    assign btnc          = r_btn[1];
    assign btnr          = r_btn[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign sent_count    = r_sent;

endmodule

`default_nettype wire
